// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder for the icache/dcache request
// protocol. It arbitrates between the two caches and runs one fixed-latency
// RAM access at a time: IDLE (grant) -> BUSY (LAT cycles) -> DONE (wait low).
module cache_mem_responder #(
  parameter int LAT = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic       OWN_I    = 1'b0;
  localparam logic       OWN_D    = 1'b1;
  localparam logic       OP_READ  = 1'b0;
  localparam logic       OP_WRITE = 1'b1;
  // The last BUSY cycle is the one in which the counter reads LAT-1.
  localparam logic [7:0] LAST_CNT = 8'(LAT - 1);

  state_t      r_state;
  logic        r_owner;
  logic        r_op;
  logic        r_last_owner;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_store;
  logic [31:0] r_rdata;
  logic        r_iwait;
  logic        r_dwait;
  logic        r_ramREN;
  logic        r_ramWEN;

  logic w_ireq;
  logic w_dreq;
  logic w_any_req;
  logic w_grant_d;

  // Request decode and arbitration: on a tie the port that was not served
  // last wins, so each port waits at most one foreign transaction.
  always_comb begin
    w_ireq    = iREN;
    w_dreq    = dREN | dWEN;
    w_any_req = w_ireq | w_dreq;
    w_grant_d = w_dreq & (~w_ireq | (r_last_owner == OWN_I));
  end

  // Transaction sequencer; all outputs are registered so the RAM strobes and
  // the wait pulse line up exactly with the BUSY and DONE cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_I;
      r_op         <= OP_READ;
      r_last_owner <= OWN_I;
      r_cnt        <= 8'd0;
      r_addr       <= 32'd0;
      r_store      <= 32'd0;
      r_rdata      <= 32'd0;
      r_iwait      <= 1'b1;
      r_dwait      <= 1'b1;
      r_ramREN     <= 1'b0;
      r_ramWEN     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_iwait <= 1'b1;
          r_dwait <= 1'b1;
          if (w_any_req) begin
            // The address/data registers feed the RAM directly, so they
            // only change here and hold their value outside BUSY.
            r_owner  <= w_grant_d ? OWN_D : OWN_I;
            r_op     <= (w_grant_d & dWEN) ? OP_WRITE : OP_READ;
            r_addr   <= w_grant_d ? daddr : iaddr;
            r_store  <= dstore;
            r_cnt    <= 8'd0;
            r_ramREN <= ~(w_grant_d & dWEN);
            r_ramWEN <= w_grant_d & dWEN;
            r_state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          r_cnt <= r_cnt + 8'd1;
          if (r_cnt == LAST_CNT) begin
            if (r_op == OP_READ) begin
              r_rdata <= ramload;
            end
            r_ramREN <= 1'b0;
            r_ramWEN <= 1'b0;
            if (r_owner == OWN_D) begin
              r_dwait <= 1'b0;
            end else begin
              r_iwait <= 1'b0;
            end
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_iwait      <= 1'b1;
          r_dwait      <= 1'b1;
          r_last_owner <= r_owner;
          r_state      <= ST_IDLE;
        end
        default: begin
          r_state  <= ST_IDLE;
          r_iwait  <= 1'b1;
          r_dwait  <= 1'b1;
          r_ramREN <= 1'b0;
          r_ramWEN <= 1'b0;
        end
      endcase
    end
  end

  // Both caches see the same read-data register; it is only meaningful in
  // the owner's DONE cycle.
  always_comb begin
    iwait    = r_iwait;
    dwait    = r_dwait;
    iload    = r_rdata;
    dload    = r_rdata;
    ramREN   = r_ramREN;
    ramWEN   = r_ramWEN;
    ramaddr  = r_addr;
    ramstore = r_store;
  end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Testbench for cache_mem_responder: a cycle table covering reset, reads,
// writes, request drop and arbitration, plus a hand-written sequence for an
// asynchronous reset in the middle of a RAM access.
module tb_cache_mem_responder;

  localparam int LAT = 2;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;

  int checks = 0;
  int errors = 0;
  int age;

  cache_mem_responder #(.LAT(LAT)) u_dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RAM contents as a fixed function of the address.
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // RAM model: data only becomes valid once ramREN has been held LAT cycles.
  always @(posedge CLK or posedge RST) begin
    if (RST) age <= 0;
    else     age <= ramREN ? age + 1 : 0;
  end

  always_comb begin
    ramload = 32'h0BAD0BAD;
    if (ramREN && age >= LAT - 1) ramload = mem_val(ramaddr);
  end

  typedef struct {
    logic        rst;
    logic        i_ren;
    logic        d_ren;
    logic        d_wen;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] ds;
    logic        e_iwait;
    logic        e_dwait;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic [31:0] e_store;
    logic [31:0] e_load;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic i_ren, input logic d_ren,
                     input logic d_wen, input logic [31:0] ia,
                     input logic [31:0] da, input logic [31:0] ds,
                     input logic e_iwait, input logic e_dwait,
                     input logic e_ren, input logic e_wen,
                     input logic [31:0] e_addr, input logic [31:0] e_store,
                     input logic [31:0] e_load);
    vec_t v;
    v.rst = rst; v.i_ren = i_ren; v.d_ren = d_ren; v.d_wen = d_wen;
    v.ia = ia; v.da = da; v.ds = ds;
    v.e_iwait = e_iwait; v.e_dwait = e_dwait; v.e_ren = e_ren; v.e_wen = e_wen;
    v.e_addr = e_addr; v.e_store = e_store; v.e_load = e_load;
    vecs.push_back(v);
  endtask

  task automatic check32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic        seen_low;
    int          lat_seen;
    RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dstore = 32'h0;

    //   rst i d w  iaddr         daddr         dstore        iw dw rR rW ramaddr       ramstore  load
    // reset with active inputs
    add(1, 1,1,1, 32'h1234, 32'h5678, 32'h9ABC,   1,1, 0,0, 32'h0,     32'h0, 32'h0);
    add(1, 1,1,1, 32'h1234, 32'h5678, 32'h9ABC,   1,1, 0,0, 32'h0,     32'h0, 32'h0);
    add(1, 1,1,1, 32'h1234, 32'h5678, 32'h9ABC,   1,1, 0,0, 32'h0,     32'h0, 32'h0);
    // dcache read of 0x100
    add(0, 0,1,0, 32'h0,    32'h100,  32'h0,      1,1, 0,0, 32'h0,     32'h0, 32'h0);
    add(0, 0,0,0, 32'h0,    32'h100,  32'h0,      1,1, 1,0, 32'h100,   32'h0, 32'h0);
    add(0, 0,0,0, 32'h0,    32'h100,  32'h0,      1,1, 1,0, 32'h100,   32'h0, 32'h0);
    add(0, 0,0,0, 32'h0,    32'h100,  32'h0,      1,0, 0,0, 32'h100,   32'h0, 32'hDEADBEEF);
    // dcache write (dREN and dWEN both high) to 0x3100
    add(0, 0,1,1, 32'h0,    32'h3100, 32'h5,      1,1, 0,0, 32'h100,   32'h0, 32'hDEADBEEF);
    add(0, 0,0,0, 32'h0,    32'h3100, 32'h0,      1,1, 0,1, 32'h3100,  32'h5, 32'hDEADBEEF);
    add(0, 0,0,0, 32'h0,    32'h3100, 32'h0,      1,1, 0,1, 32'h3100,  32'h5, 32'hDEADBEEF);
    add(0, 0,0,0, 32'h0,    32'h3100, 32'h0,      1,0, 0,0, 32'h3100,  32'h5, 32'hDEADBEEF);
    // read of 0x200 with dREN dropped in the first BUSY cycle
    add(0, 0,1,0, 32'h0,    32'h200,  32'h0,      1,1, 0,0, 32'h3100,  32'h5, 32'hDEADBEEF);
    add(0, 0,0,0, 32'h0,    32'h200,  32'h0,      1,1, 1,0, 32'h200,   32'h0, 32'hDEADBEEF);
    add(0, 0,0,0, 32'h0,    32'h200,  32'h0,      1,1, 1,0, 32'h200,   32'h0, 32'hDEADBEEF);
    add(0, 0,0,0, 32'h0,    32'h200,  32'h0,      1,0, 0,0, 32'h200,   32'h0, 32'h0200FDFF);
    add(0, 0,0,0, 32'h0,    32'h200,  32'h0,      1,1, 0,0, 32'h200,   32'h0, 32'h0200FDFF);
    add(0, 0,0,0, 32'h0,    32'h200,  32'h0,      1,1, 0,0, 32'h200,   32'h0, 32'h0200FDFF);
    // reset, then both ports request continuously: D, I, D
    add(1, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 0,0, 32'h0,     32'h0, 32'h0);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 0,0, 32'h0,     32'h0, 32'h0);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 1,0, 32'h80,    32'h0, 32'h0);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 1,0, 32'h80,    32'h0, 32'h0);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,0, 0,0, 32'h80,    32'h0, 32'h0080FF7F);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 0,0, 32'h80,    32'h0, 32'h0080FF7F);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 1,0, 32'h40,    32'h0, 32'h0080FF7F);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 1,0, 32'h40,    32'h0, 32'h0080FF7F);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      0,1, 0,0, 32'h40,    32'h0, 32'h0040FFBF);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 0,0, 32'h40,    32'h0, 32'h0040FFBF);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 1,0, 32'h80,    32'h0, 32'h0040FFBF);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,1, 1,0, 32'h80,    32'h0, 32'h0040FFBF);
    add(0, 1,1,0, 32'h40,   32'h80,   32'h0,      1,0, 0,0, 32'h80,    32'h0, 32'h0080FF7F);
    add(0, 0,0,0, 32'h0,    32'h0,    32'h0,      1,1, 0,0, 32'h80,    32'h0, 32'h0080FF7F);

    // Inputs change just after the rising edge; outputs are compared on the
    // falling edge of the same cycle.
    for (int k = 0; k < vecs.size(); k++) begin
      @(posedge CLK);
      #1;
      RST = vecs[k].rst; iREN = vecs[k].i_ren; dREN = vecs[k].d_ren;
      dWEN = vecs[k].d_wen; iaddr = vecs[k].ia; daddr = vecs[k].da;
      dstore = vecs[k].ds;
      @(negedge CLK);
      check32($sformatf("row%0d iwait", k), {31'd0, iwait}, {31'd0, vecs[k].e_iwait});
      check32($sformatf("row%0d dwait", k), {31'd0, dwait}, {31'd0, vecs[k].e_dwait});
      check32($sformatf("row%0d ramREN", k), {31'd0, ramREN}, {31'd0, vecs[k].e_ren});
      check32($sformatf("row%0d ramWEN", k), {31'd0, ramWEN}, {31'd0, vecs[k].e_wen});
      check32($sformatf("row%0d ramaddr", k), ramaddr, vecs[k].e_addr);
      check32($sformatf("row%0d ramstore", k), ramstore, vecs[k].e_store);
      check32($sformatf("row%0d dload", k), dload, vecs[k].e_load);
      check32($sformatf("row%0d iload", k), iload, vecs[k].e_load);
      $display("row %0d: iw=%0b dw=%0b ren=%0b wen=%0b addr=%h load=%h",
               k, iwait, dwait, ramREN, ramWEN, ramaddr, dload);
    end

    // Reset asserted in the second BUSY cycle of an icache read.
    @(posedge CLK); #1; iREN = 1'b1; iaddr = 32'h44;
    @(posedge CLK); #1; iREN = 1'b0;
    @(posedge CLK); #2; RST = 1'b1;
    #1;
    check32("midbusy ramREN", {31'd0, ramREN}, 32'd0);
    check32("midbusy iwait", {31'd0, iwait}, 32'd1);
    check32("midbusy ramaddr", ramaddr, 32'h0);
    check32("midbusy iload", iload, 32'h0);
    @(negedge CLK); RST = 1'b0;
    seen_low = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      if (!iwait || !dwait || ramREN) seen_low = 1'b1;
    end
    check32("abandoned no pulse", {31'd0, seen_low}, 32'd0);
    $display("reset mid-BUSY: abandoned transaction, no wait pulse seen=%0b", seen_low);

    // Fresh icache read after the reset completes with LAT+1 cycle latency.
    @(posedge CLK); #1; iREN = 1'b1; iaddr = 32'h48;
    lat_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK);
      if (k == 1) begin #1; iREN = 1'b0; end
      @(negedge CLK);
      if (!iwait) begin lat_seen = k; break; end
    end
    check32("post-reset latency", lat_seen, LAT + 1);
    check32("post-reset iload", iload, mem_val(32'h48));
    $display("post-reset read: latency=%0d iload=%h", lat_seen, iload);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
